instr_encoder_seq: RTL and testbench
====================================

Name: instr_encoder_seq

Overview:
Instruction encoder and sequencer: converts compact debug/test commands (op, registers, immediate, CSR address) into legal RV32 instruction words.
Emits the words in order on a valid/ready stream that feeds the fetch-side injection path (debug program buffer / self-test instruction source).
Forms the encode side of the instruction-pattern decoding used by the tracer.
Expands LI into LUI+ADDI when needed and applies backpressure per word.

Parameters:
CNT_W, 16, width of emitted-word counter
XLEN_IMM, 32, width of command immediate

Ports:
clk_i  in  1  clock
rst_i  in  1  asynchronous reset, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid&&ready
cmd_op_i  in  4  0 NOP, 1 LI, 2 ADDI, 3 LW, 4 SW, 5 CSRR, 6 CSRW, 7 JAL, 8 EBREAK, 9 FENCE.I, others illegal
cmd_rd_i  in  5  destination register
cmd_rs1_i  in  5  source 1 / base register
cmd_rs2_i  in  5  source 2 (SW data, CSRW source)
cmd_imm_i  in  XLEN_IMM  immediate / offset
cmd_csr_i  in  12  CSR address
instr_valid_o  out  1  instruction word valid
instr_ready_i  in  1  consumer ready
instr_o  out  32  encoded instruction
flush_i  in  1  drop pending words, return to IDLE
busy_o  out  1  state!=IDLE or instr_valid_o
illegal_o  out  1  one-cycle pulse: accepted command was illegal
count_o  out  CNT_W  number of words handshaken, wraps

Behaviour:
- Reset (async, immediate): state IDLE, instr_valid_o=0, instr_o=0, illegal_o=0, count_o=0, busy_o=0, cmd_ready_o=0 while rst_i high.
- States:
  - IDLE: no second word pending.
  - HOLD2: first LI word is in the output register; the second word is in a pending register.
- cmd_ready_o = (state==IDLE) && (!instr_valid_o || instr_ready_i) && !flush_i.
- Accept at edge N: the first word is registered, and instr_valid_o=1 from cycle N+1. There is no combinational path from cmd_* to instr_o.
- Output stays stable while instr_valid_o && !instr_ready_i.
- Handshake (valid&&ready): count_o increments by 1, wrapping at 2^CNT_W.
- In HOLD2, a handshake loads the pending word, instr_valid_o stays 1, and the state returns to IDLE. The next command can be accepted once that word handshakes.
- Encodings:
  - NOP: 0x00000013.
  - ADDI: rd, rs1, imm[11:0].
  - LW: rd, imm(rs1), funct3=010.
  - SW: rs2, imm(rs1), funct3=010.
  - CSRR: csrrs rd, csr, x0.
  - CSRW: csrrw x0, csr, rs2 (rs2 placed in the rs1 field).
  - JAL: rd, imm[20:1].
  - EBREAK: 0x00100073.
  - FENCE.I: 0x0000100F.
- LI:
  - If imm is within [-2048, 2047]: single word, addi rd, x0, imm.
  - Else: upper = (imm + 0x800)[31:12] with 32-bit wrap.
    - If imm[11:0]==0: single word, lui rd, upper.
    - Otherwise: lui rd, upper, then addi rd, rd, imm[11:0], entering HOLD2.
- Illegal:
  - Undefined op.
  - ADDI/LW/SW imm outside signed 12-bit range.
  - JAL imm[0]=1 or imm outside [-2^20, 2^20-2].
  - An illegal command is accepted (consumed), emits no word, and gives illegal_o=1 for exactly cycle N+1. count_o is unchanged.
- flush_i (synchronous, highest priority):
  - Next edge: instr_valid_o=0, pending word discarded, state IDLE, no count increment even if instr_ready_i was high.
  - No command is accepted in a flush cycle.
- Reset mid-sequence (HOLD2): everything is cleared and no second word is emitted afterwards.
- cmd_* is ignored when cmd_valid_i && !cmd_ready_o. The sender must hold it stable.

Test Plan:
- Reset, then LI rd=5 imm=0x12345678, instr_ready_i=1 -> instr_o 0x123452B7 then 0x67828293 on consecutive cycles; count_o=2; cmd_ready_o low during HOLD2.
- LI rd=1 imm=0x800 -> 0x000010B7, 0x80008093. LI rd=10 imm=-1 -> single 0xFFF00513. LI rd=3 imm=0x5000 -> single 0x000051B7.
- CSRR rd=2 csr=0x300 with instr_ready_i held low 3 cycles -> instr_o=0x30002173 stable all 3 cycles; count_o increments only on the ready cycle; cmd_ready_o=0 meanwhile.
- op=0xF, then ADDI imm=4096 -> each accepted, illegal_o one-cycle pulse each, instr_valid_o stays 0, count_o unchanged.
- LI 0x12345678 with instr_ready_i=0, flush_i pulsed in HOLD2 -> instr_valid_o=0 next cycle, 0x67828293 never appears, count_o=0, busy_o=0.
- Back-to-back NOPs with instr_ready_i=1, count_o preset near wrap (0xFFFE after 65534 words, or a CNT_W=4 build) -> one word per cycle, count_o wraps to 0; rst_i asserted mid-stream -> outputs clear immediately.

Source files
------------

// File: rtl/instr_encoder_seq.sv
// Instruction encoder/sequencer: turns compact debug/test commands into RV32
// instruction words and streams them out on a valid/ready interface. LI with a
// wide immediate expands into LUI followed by ADDI.
module instr_encoder_seq #(
  parameter int CNT_W    = 16,
  parameter int XLEN_IMM = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                cmd_valid_i,
  output logic                cmd_ready_o,
  input  logic [3:0]          cmd_op_i,
  input  logic [4:0]          cmd_rd_i,
  input  logic [4:0]          cmd_rs1_i,
  input  logic [4:0]          cmd_rs2_i,
  input  logic [XLEN_IMM-1:0] cmd_imm_i,
  input  logic [11:0]         cmd_csr_i,
  output logic                instr_valid_o,
  input  logic                instr_ready_i,
  output logic [31:0]         instr_o,
  input  logic                flush_i,
  output logic                busy_o,
  output logic                illegal_o,
  output logic [CNT_W-1:0]    count_o
);

  typedef enum logic {S_IDLE, S_HOLD2} state_t;

  localparam logic [3:0] OP_NOP = 4'd0, OP_LI = 4'd1, OP_ADDI = 4'd2, OP_LW = 4'd3,
                         OP_SW = 4'd4, OP_CSRR = 4'd5, OP_CSRW = 4'd6, OP_JAL = 4'd7,
                         OP_EBREAK = 4'd8, OP_FENCEI = 4'd9;

  localparam logic signed [XLEN_IMM-1:0] I12_MIN = -2048;
  localparam logic signed [XLEN_IMM-1:0] I12_MAX = 2047;
  localparam logic signed [XLEN_IMM-1:0] J_MIN   = -(1 << 20);
  localparam logic signed [XLEN_IMM-1:0] J_MAX   = (1 << 20) - 2;

  state_t            r_state, w_state_nxt;
  logic              r_valid, r_ill;
  logic [31:0]       r_instr, r_pend;
  logic [CNT_W-1:0]  r_count;

  logic [31:0] w_imm, w_upper, w_word0, w_word1;
  logic [11:0] w_lo;
  logic        w_fit12, w_jfit, w_two, w_ill, w_hs, w_acc;

  assign w_imm   = cmd_imm_i[31:0];
  assign w_lo    = w_imm[11:0];
  // Rounding +0x800 compensates for the sign-extension of the ADDI low part.
  assign w_upper = w_imm + 32'h0000_0800;
  assign w_fit12 = ($signed(cmd_imm_i) >= I12_MIN) && ($signed(cmd_imm_i) <= I12_MAX);
  assign w_jfit  = ($signed(cmd_imm_i) >= J_MIN) && ($signed(cmd_imm_i) <= J_MAX) && !w_imm[0];

  assign w_hs        = r_valid && instr_ready_i;
  assign cmd_ready_o = !rst_i && (r_state == S_IDLE) && (!r_valid || instr_ready_i) && !flush_i;
  assign w_acc       = cmd_valid_i && cmd_ready_o;

  assign instr_valid_o = r_valid;
  assign instr_o       = r_instr;
  assign illegal_o     = r_ill;
  assign count_o       = r_count;
  assign busy_o        = (r_state != S_IDLE) || r_valid;

  // Encode the presented command into one or two words plus an illegal flag.
  always_comb begin
    w_word0 = 32'h0000_0013;
    w_word1 = 32'h0000_0013;
    w_two   = 1'b0;
    w_ill   = 1'b0;
    case (cmd_op_i)
      OP_NOP:    w_word0 = 32'h0000_0013;
      OP_LI: begin
        if (w_fit12) begin
          w_word0 = {w_lo, 5'd0, 3'b000, cmd_rd_i, 7'b0010011};
        end else begin
          w_word0 = {w_upper[31:12], cmd_rd_i, 7'b0110111};
          w_word1 = {w_lo, cmd_rd_i, 3'b000, cmd_rd_i, 7'b0010011};
          w_two   = (w_lo != 12'd0);
        end
      end
      OP_ADDI: begin
        w_word0 = {w_lo, cmd_rs1_i, 3'b000, cmd_rd_i, 7'b0010011};
        w_ill   = !w_fit12;
      end
      OP_LW: begin
        w_word0 = {w_lo, cmd_rs1_i, 3'b010, cmd_rd_i, 7'b0000011};
        w_ill   = !w_fit12;
      end
      OP_SW: begin
        w_word0 = {w_lo[11:5], cmd_rs2_i, cmd_rs1_i, 3'b010, w_lo[4:0], 7'b0100011};
        w_ill   = !w_fit12;
      end
      OP_CSRR:   w_word0 = {cmd_csr_i, 5'd0, 3'b010, cmd_rd_i, 7'b1110011};
      OP_CSRW:   w_word0 = {cmd_csr_i, cmd_rs2_i, 3'b001, 5'd0, 7'b1110011};
      OP_JAL: begin
        w_word0 = {w_imm[20], w_imm[10:1], w_imm[11], w_imm[19:12], cmd_rd_i, 7'b1101111};
        w_ill   = !w_jfit;
      end
      OP_EBREAK: w_word0 = 32'h0010_0073;
      OP_FENCEI: w_word0 = 32'h0000_100F;
      default:   w_ill   = 1'b1;
    endcase
  end

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state: HOLD2 while the ADDI half of a split LI waits its turn.
  always_comb begin
    w_state_nxt = r_state;
    if (flush_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (w_acc && !w_ill && w_two) w_state_nxt = S_HOLD2;
        S_HOLD2: if (w_hs) w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Output register, pending second word, illegal pulse and word counter.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid <= 1'b0;
      r_instr <= 32'd0;
      r_pend  <= 32'd0;
      r_ill   <= 1'b0;
      r_count <= '0;
    end else if (flush_i) begin
      r_valid <= 1'b0;
      r_ill   <= 1'b0;
    end else begin
      r_ill <= w_acc && w_ill;
      if (w_hs) r_count <= r_count + CNT_W'(1);
      if (r_state == S_HOLD2 && w_hs) begin
        r_instr <= r_pend;
      end else if (w_acc && !w_ill) begin
        r_instr <= w_word0;
        r_valid <= 1'b1;
        if (w_two) r_pend <= w_word1;
      end else if (w_hs) begin
        r_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder_seq.sv
// Bench for instr_encoder_seq: directed scenarios plus randomized commands
// checked against a word-queue model of the output stream.
module tb_instr_encoder_seq;
  localparam int CNT_W = 4;

  logic              clk_i = 1'b0;
  logic              rst_i;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [3:0]        cmd_op_i;
  logic [4:0]        cmd_rd_i, cmd_rs1_i, cmd_rs2_i;
  logic [31:0]       cmd_imm_i;
  logic [11:0]       cmd_csr_i;
  logic              instr_valid_o;
  logic              instr_ready_i;
  logic [31:0]       instr_o;
  logic              flush_i;
  logic              busy_o;
  logic              illegal_o;
  logic [CNT_W-1:0]  count_o;

  instr_encoder_seq #(.CNT_W(CNT_W), .XLEN_IMM(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_op_i(cmd_op_i), .cmd_rd_i(cmd_rd_i), .cmd_rs1_i(cmd_rs1_i), .cmd_rs2_i(cmd_rs2_i),
    .cmd_imm_i(cmd_imm_i), .cmd_csr_i(cmd_csr_i), .instr_valid_o(instr_valid_o),
    .instr_ready_i(instr_ready_i), .instr_o(instr_o), .flush_i(flush_i), .busy_o(busy_o),
    .illegal_o(illegal_o), .count_o(count_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Model: words not yet handshaken (head = word on the output), count, pulse.
  logic [31:0] q[$];
  int          ecnt;
  bit          eill;

  function automatic bit fits(input int v, input int lo, input int hi);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic void enc(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr,
                              output int n, output logic [31:0] w0, output logic [31:0] w1,
                              output bit ill);
    int si;
    logic [31:0] d, s1, s2, c, lo, up;
    si = int'($signed(imm));
    d  = {27'd0, rd};
    s1 = {27'd0, rs1};
    s2 = {27'd0, rs2};
    c  = {20'd0, csr};
    lo = imm & 32'hFFF;
    n = 1; w0 = 32'd0; w1 = 32'd0; ill = 1'b0;
    case (op)
      4'd0: w0 = 32'h13;
      4'd1: begin
        if (fits(si, -2048, 2047)) w0 = (lo << 20) | (d << 7) | 32'h13;
        else begin
          up = (imm + 32'h800) >> 12;
          w0 = (up << 12) | (d << 7) | 32'h37;
          if (lo != 0) begin
            n = 2;
            w1 = (lo << 20) | (d << 15) | (d << 7) | 32'h13;
          end
        end
      end
      4'd2: begin ill = !fits(si, -2048, 2047); w0 = (lo << 20) | (s1 << 15) | (d << 7) | 32'h13; end
      4'd3: begin ill = !fits(si, -2048, 2047); w0 = (lo << 20) | (s1 << 15) | (2 << 12) | (d << 7) | 32'h03; end
      4'd4: begin
        ill = !fits(si, -2048, 2047);
        w0 = ((lo >> 5) << 25) | (s2 << 20) | (s1 << 15) | (2 << 12) | ((lo & 31) << 7) | 32'h23;
      end
      4'd5: w0 = (c << 20) | (2 << 12) | (d << 7) | 32'h73;
      4'd6: w0 = (c << 20) | (s2 << 15) | (1 << 12) | 32'h73;
      4'd7: begin
        ill = imm[0] || !fits(si, -(1 << 20), (1 << 20) - 2);
        w0 = (((imm >> 20) & 1) << 31) | (((imm >> 1) & 32'h3FF) << 21) |
             (((imm >> 11) & 1) << 20) | (((imm >> 12) & 32'hFF) << 12) | (d << 7) | 32'h6F;
      end
      4'd8: w0 = 32'h0010_0073;
      4'd9: w0 = 32'h0000_100F;
      default: ill = 1'b1;
    endcase
    if (ill) n = 0;
  endfunction

  function automatic bit exp_ready();
    return !flush_i && (q.size() == 0 || (q.size() == 1 && instr_ready_i));
  endfunction

  // Advance one clock and move the model along with it (no checking here).
  task automatic step();
    bit hs, acc, il;
    int n;
    logic [31:0] w0, w1;
    hs  = (q.size() > 0) && instr_ready_i && !flush_i;
    acc = cmd_valid_i && exp_ready();
    enc(cmd_op_i, cmd_rd_i, cmd_rs1_i, cmd_rs2_i, cmd_imm_i, cmd_csr_i, n, w0, w1, il);
    @(posedge clk_i);
    eill = 1'b0;
    if (flush_i) q.delete();
    else begin
      if (hs) begin
        void'(q.pop_front());
        ecnt = (ecnt + 1) % (1 << CNT_W);
      end
      if (acc) begin
        if (il) eill = 1'b1;
        else begin
          q.push_back(w0);
          if (n == 2) q.push_back(w1);
        end
      end
    end
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [31:0] imm, input logic [11:0] csr);
    cmd_op_i = op; cmd_rd_i = rd; cmd_rs1_i = rs1; cmd_rs2_i = rs2; cmd_imm_i = imm; cmd_csr_i = csr;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b0; flush_i = 1'b0; instr_ready_i = 1'b0;
    q.delete(); ecnt = 0; eill = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst_i = 1'b1; cmd_valid_i = 1'b1; instr_ready_i = 1'b1; flush_i = 1'b0;
    set_cmd(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
    q.delete(); ecnt = 0; eill = 1'b0;
    @(posedge clk_i); #1;
    total++;
    if ({instr_valid_o, illegal_o, busy_o, cmd_ready_o} !== 4'b0000 || instr_o !== 32'd0 || count_o !== '0) begin
      bad++;
      $display("FAIL reset: vld=%b ill=%b busy=%b rdy=%b instr=%h cnt=%0d want all zero",
               instr_valid_o, illegal_o, busy_o, cmd_ready_o, instr_o, count_o);
    end
    rst_i = 1'b0; cmd_valid_i = 1'b0; #1;
  endtask

  task automatic test_li(input logic [4:0] rd, input logic [31:0] imm, input logic [31:0] e0,
                         input logic [31:0] e1, input bit two);
    int c0;
    c0 = ecnt;
    set_cmd(4'd1, rd, 5'd0, 5'd0, imm, 12'd0);
    cmd_valid_i = 1'b1; instr_ready_i = 1'b1; flush_i = 1'b0; #1;
    total++;
    if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL li_ready: got %b want 1", cmd_ready_o); end
    step(); cmd_valid_i = 1'b0; #1;
    total++;
    if (instr_valid_o !== 1'b1 || instr_o !== e0) begin
      bad++; $display("FAIL li_word0 imm=%h: vld=%b instr=%h want %h", imm, instr_valid_o, instr_o, e0);
    end
    if (two) begin
      total++;
      if (cmd_ready_o !== 1'b0 || busy_o !== 1'b1) begin
        bad++; $display("FAIL li_hold2: rdy=%b busy=%b want 0 1", cmd_ready_o, busy_o);
      end
      step();
      total++;
      if (instr_valid_o !== 1'b1 || instr_o !== e1) begin
        bad++; $display("FAIL li_word1 imm=%h: vld=%b instr=%h want %h", imm, instr_valid_o, instr_o, e1);
      end
    end
    step();
    total++;
    if (instr_valid_o !== 1'b0 || count_o !== CNT_W'((c0 + (two ? 2 : 1)) % (1 << CNT_W))) begin
      bad++; $display("FAIL li_done: vld=%b cnt=%0d want 0 %0d", instr_valid_o, count_o, (c0 + (two ? 2 : 1)) % (1 << CNT_W));
    end
  endtask

  task automatic test_stall();
    int c0;
    c0 = ecnt;
    set_cmd(4'd5, 5'd2, 5'd0, 5'd0, 32'd0, 12'h300);
    cmd_valid_i = 1'b1; instr_ready_i = 1'b0; #1;
    step(); cmd_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cmd_valid_i = 1'b1; #1;
      total++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'h30002173 || cmd_ready_o !== 1'b0 || count_o !== CNT_W'(c0)) begin
        bad++; $display("FAIL stall[%0d]: vld=%b instr=%h rdy=%b cnt=%0d want 1 30002173 0 %0d",
                        k, instr_valid_o, instr_o, cmd_ready_o, count_o, c0);
      end
      cmd_valid_i = 1'b0;
      step();
    end
    instr_ready_i = 1'b1; #1;
    step();
    total++;
    if (instr_valid_o !== 1'b0 || count_o !== CNT_W'((c0 + 1) % (1 << CNT_W))) begin
      bad++; $display("FAIL stall_release: vld=%b cnt=%0d want 0 %0d", instr_valid_o, count_o, (c0 + 1) % (1 << CNT_W));
    end
  endtask

  task automatic test_illegal();
    logic [3:0]  ops[2];
    logic [31:0] imms[2];
    int c0;
    ops[0] = 4'hF; imms[0] = 32'd0;
    ops[1] = 4'd2; imms[1] = 32'd4096;
    instr_ready_i = 1'b1;
    for (int k = 0; k < 2; k++) begin
      c0 = ecnt;
      set_cmd(ops[k], 5'd7, 5'd3, 5'd4, imms[k], 12'd0);
      cmd_valid_i = 1'b1; #1;
      total++;
      if (cmd_ready_o !== 1'b1) begin bad++; $display("FAIL illegal_accept[%0d]: rdy=%b want 1", k, cmd_ready_o); end
      step(); cmd_valid_i = 1'b0; #1;
      total++;
      if (illegal_o !== 1'b1 || instr_valid_o !== 1'b0 || count_o !== CNT_W'(c0)) begin
        bad++; $display("FAIL illegal_pulse[%0d]: ill=%b vld=%b cnt=%0d want 1 0 %0d", k, illegal_o, instr_valid_o, count_o, c0);
      end
      step();
      total++;
      if (illegal_o !== 1'b0 || instr_valid_o !== 1'b0) begin
        bad++; $display("FAIL illegal_end[%0d]: ill=%b vld=%b want 0 0", k, illegal_o, instr_valid_o);
      end
    end
  endtask

  task automatic test_flush();
    set_cmd(4'd1, 5'd5, 5'd0, 5'd0, 32'h12345678, 12'd0);
    cmd_valid_i = 1'b1; instr_ready_i = 1'b0; #1;
    step(); cmd_valid_i = 1'b0;
    step();
    flush_i = 1'b1; instr_ready_i = 1'b1; cmd_valid_i = 1'b1; #1;
    total++;
    if (cmd_ready_o !== 1'b0) begin bad++; $display("FAIL flush_ready: rdy=%b want 0", cmd_ready_o); end
    step();
    flush_i = 1'b0; cmd_valid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      total++;
      if (instr_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== '0) begin
        bad++; $display("FAIL flush[%0d]: vld=%b busy=%b cnt=%0d instr=%h want 0 0 0", k, instr_valid_o, busy_o, count_o, instr_o);
      end
      step();
    end
  endtask

  task automatic test_back_to_back();
    set_cmd(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
    cmd_valid_i = 1'b1; instr_ready_i = 1'b1; #1;
    step();
    for (int k = 0; k < 18; k++) begin
      total++;
      if (instr_valid_o !== 1'b1 || instr_o !== 32'h13 || count_o !== CNT_W'(ecnt) || count_o !== CNT_W'(k)) begin
        bad++; $display("FAIL b2b[%0d]: vld=%b instr=%h cnt=%0d want 1 00000013 %0d", k, instr_valid_o, instr_o, count_o, k % 16);
      end
      step();
    end
    // Counter is now past its wrap point; an async reset must clear at once.
    rst_i = 1'b1; #1;
    total++;
    if ({instr_valid_o, busy_o, cmd_ready_o, illegal_o} !== 4'b0000 || count_o !== '0 || instr_o !== 32'd0) begin
      bad++; $display("FAIL reset_mid: vld=%b busy=%b rdy=%b cnt=%0d instr=%h want all zero",
                      instr_valid_o, busy_o, cmd_ready_o, count_o, instr_o);
    end
    q.delete(); ecnt = 0; eill = 1'b0; cmd_valid_i = 1'b0;
    @(posedge clk_i); #1; rst_i = 1'b0; #1;
  endtask

  task automatic test_reset_hold2();
    set_cmd(4'd1, 5'd5, 5'd0, 5'd0, 32'h12345678, 12'd0);
    cmd_valid_i = 1'b1; instr_ready_i = 1'b0; #1;
    step(); cmd_valid_i = 1'b0;
    rst_i = 1'b1; q.delete(); ecnt = 0; eill = 1'b0; #2;
    rst_i = 1'b0; instr_ready_i = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      total++;
      if (instr_valid_o !== 1'b0 || busy_o !== 1'b0 || count_o !== '0) begin
        bad++; $display("FAIL reset_hold2[%0d]: vld=%b busy=%b cnt=%0d instr=%h want 0 0 0", k, instr_valid_o, busy_o, count_o, instr_o);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] edges[8];
    bit pend;
    bit acc;
    int sel;
    edges[0] = 32'd2047; edges[1] = 32'd2048; edges[2] = 32'hFFFF_F800; edges[3] = 32'hFFFF_F7FF;
    edges[4] = 32'h800;  edges[5] = 32'h5000; edges[6] = 32'hFFFF_F000; edges[7] = 32'h7FFF_F800;
    pend = 1'b0;
    for (int i = 0; i < 800; i++) begin
      if (!pend) begin
        sel = int'($urandom_range(0, 5));
        set_cmd(4'($urandom_range(0, 11)), 5'($urandom), 5'($urandom), 5'($urandom), 32'd0, 12'($urandom));
        case (sel)
          0: cmd_imm_i = 32'($urandom_range(0, 4095)) - 32'd2048;
          1: cmd_imm_i = $urandom;
          2: cmd_imm_i = edges[$urandom_range(0, 7)];
          3: cmd_imm_i = 32'($urandom_range(0, (1 << 21) - 1)) - 32'h0010_0000;
          4: cmd_imm_i = $urandom << 12;
          default: cmd_imm_i = 32'($urandom_range(0, 40));
        endcase
        cmd_valid_i = ($urandom_range(0, 2) != 0);
        pend = cmd_valid_i;
      end
      instr_ready_i = ($urandom_range(0, 3) != 0);
      flush_i       = ($urandom_range(0, 39) == 0);
      #1;
      total++;
      if (cmd_ready_o !== exp_ready() || instr_valid_o !== (q.size() > 0) || busy_o !== (q.size() > 0) ||
          illegal_o !== eill || count_o !== CNT_W'(ecnt) || (q.size() > 0 && instr_o !== q[0])) begin
        bad++;
        $display("FAIL rand[%0d]: rdy=%b vld=%b busy=%b ill=%b cnt=%0d instr=%h want %b %b %b %b %0d %h",
                 i, cmd_ready_o, instr_valid_o, busy_o, illegal_o, count_o, instr_o,
                 exp_ready(), q.size() > 0, q.size() > 0, eill, ecnt, (q.size() > 0) ? q[0] : 32'd0);
      end
      acc = cmd_valid_i && exp_ready();
      step();
      if (acc) begin pend = 1'b0; cmd_valid_i = 1'b0; end
    end
    flush_i = 1'b0; cmd_valid_i = 1'b0;
  endtask

  initial begin
    rst_i = 1'b1; cmd_valid_i = 1'b0; instr_ready_i = 1'b0; flush_i = 1'b0;
    set_cmd(4'd0, 5'd0, 5'd0, 5'd0, 32'd0, 12'd0);
    test_reset();
    test_li(5'd5,  32'h1234_5678, 32'h123452B7, 32'h67828293, 1'b1);
    test_li(5'd1,  32'h0000_0800, 32'h000010B7, 32'h80008093, 1'b1);
    test_li(5'd10, 32'hFFFF_FFFF, 32'hFFF00513, 32'd0,        1'b0);
    test_li(5'd3,  32'h0000_5000, 32'h000051B7, 32'd0,        1'b0);
    test_stall();
    test_illegal();
    do_reset();
    test_flush();
    do_reset();
    test_back_to_back();
    test_reset_hold2();
    do_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
